// File: rtl/instruction_compressor.sv
// -----------------------------------------------------------------------------
// instruction_compressor
//
// Streaming RV32I -> RV32C compressor placed between the program-image loader
// and the instruction-memory write port. Every accepted 32-bit instruction is
// re-encoded to its 16-bit RVC form when one exists. The resulting halfword
// stream is packed little-endian into 32-bit memory words, so 32-bit
// instructions may straddle word boundaries. A flush pads a trailing odd
// halfword with C.NOP (16'h0001).
//
// Optional feature macro:
//   COMPRESSOR_SHIFT_EN  - also compress SLLI, SRLI, SRAI and ANDI.
//
// Ports:
//   clk             system clock, rising edge
//   rst             asynchronous, active-high reset
//   in_valid        instruction_in valid
//   in_ready        block accepts instruction_in this cycle
//   instruction_in  uncompressed RV32I instruction
//   flush           level request: emit the pending halfword, padded
//   out_valid       out_word valid (registered)
//   out_ready       consumer accepts out_word
//   out_word        packed word, earlier halfword in [15:0]
//   idle            high when no halfword is pending (packer state is EMPTY)
//
// Handshake: a transfer happens on a rising edge where valid && ready. Once
// out_valid is high, out_valid/out_word hold until out_ready is seen high.
// in_ready = !out_valid || out_ready for every kind of input transfer, even one
// that produces no output word. A flush is taken when flush && !in_valid &&
// in_ready; an instruction arriving with flush wins that cycle.
// -----------------------------------------------------------------------------
module instruction_compressor (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instruction_in,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_word,
    output logic        idle
);

    typedef enum logic {
        EMPTY = 1'b0,
        HALF  = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Instruction fields
    // ------------------------------------------------------------------
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [11:0] imm_i;
    logic [11:0] imm_s;

    assign opcode = instruction_in[6:0];
    assign funct3 = instruction_in[14:12];
    assign funct7 = instruction_in[31:25];
    assign rd     = instruction_in[11:7];
    assign rs1    = instruction_in[19:15];
    assign rs2    = instruction_in[24:20];
    assign imm_i  = instruction_in[31:20];
    assign imm_s  = {instruction_in[31:25], instruction_in[11:7]};

    localparam logic [6:0] OP_IMM  = 7'b0010011;
    localparam logic [6:0] OP_LOAD = 7'b0000011;
    localparam logic [6:0] OP_STOR = 7'b0100011;
    localparam logic [6:0] OP_REG  = 7'b0110011;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    // Compressed register fields only reach x8..x15.
    function automatic logic is_creg(input logic [4:0] r);
        return r[4:3] == 2'b01;
    endfunction

    // A 12-bit immediate fits 6 signed bits when [11:5] is a pure sign extension.
    function automatic logic fits_simm6(input logic [11:0] v);
        return (v[11:5] == 7'h00) || (v[11:5] == 7'h7F);
    endfunction

    // C.LW/C.SW offset: word aligned, 0..124.
    function automatic logic fits_uoff7(input logic [11:0] v);
        return (v[11:7] == 5'd0) && (v[1:0] == 2'b00);
    endfunction

    // ------------------------------------------------------------------
    // Encoder: first matching rule wins; c_ok=0 means pass through 32 bits.
    // ------------------------------------------------------------------
    logic        c_ok;
    logic [15:0] c16;

    always_comb begin
        c_ok = 1'b0;
        c16  = 16'h0000;
        if (opcode == OP_IMM && funct3 == 3'b000 && rd == rs1 && rd != 5'd0 &&
            imm_i != 12'd0 && fits_simm6(imm_i)) begin
            // C.ADDI
            c_ok = 1'b1;
            c16  = {3'b000, imm_i[5], rd, imm_i[4:0], 2'b01};
        end else if (opcode == OP_IMM && funct3 == 3'b000 && rs1 == 5'd0 &&
                     rd != 5'd0 && fits_simm6(imm_i)) begin
            // C.LI
            c_ok = 1'b1;
            c16  = {3'b010, imm_i[5], rd, imm_i[4:0], 2'b01};
        end else if (opcode == OP_LOAD && funct3 == 3'b010 && is_creg(rd) &&
                     is_creg(rs1) && fits_uoff7(imm_i)) begin
            // C.LW
            c_ok = 1'b1;
            c16  = {3'b010, imm_i[5:3], rs1[2:0], imm_i[2], imm_i[6], rd[2:0], 2'b00};
        end else if (opcode == OP_STOR && funct3 == 3'b010 && is_creg(rs2) &&
                     is_creg(rs1) && fits_uoff7(imm_s)) begin
            // C.SW
            c_ok = 1'b1;
            c16  = {3'b110, imm_s[5:3], rs1[2:0], imm_s[2], imm_s[6], rs2[2:0], 2'b00};
        end else if (opcode == OP_REG && funct3 == 3'b000 && funct7 == 7'b0000000 &&
                     rd == rs1 && rd != 5'd0 && rs2 != 5'd0) begin
            // C.ADD
            c_ok = 1'b1;
            c16  = {4'b1001, rd, rs2, 2'b10};
        end else if (opcode == OP_REG && funct3 == 3'b000 && funct7 == 7'b0000000 &&
                     rs1 == 5'd0 && rd != 5'd0 && rs2 != 5'd0) begin
            // C.MV
            c_ok = 1'b1;
            c16  = {4'b1000, rd, rs2, 2'b10};
        end else if (opcode == OP_REG && rd == rs1 && is_creg(rd) && is_creg(rs2) &&
                     ((funct7 == 7'b0100000 && funct3 == 3'b000) ||
                      (funct7 == 7'b0000000 && (funct3 == 3'b100 ||
                                                funct3 == 3'b110 ||
                                                funct3 == 3'b111)))) begin
            // C.SUB / C.XOR / C.OR / C.AND, selected by bits [6:5]
            c_ok = 1'b1;
            c16  = {6'b100011, rd[2:0], 2'b00, rs2[2:0], 2'b01};
            case (funct3)
                3'b100:  c16[6:5] = 2'b01;
                3'b110:  c16[6:5] = 2'b10;
                3'b111:  c16[6:5] = 2'b11;
                default: c16[6:5] = 2'b00;
            endcase
        end else if (opcode == OP_JALR && funct3 == 3'b000 && imm_i == 12'd0 &&
                     rs1 != 5'd0 && (rd == 5'd0 || rd == 5'd1)) begin
            // C.JR (rd=x0) / C.JALR (rd=x1)
            c_ok = 1'b1;
            c16  = {3'b100, rd[0], rs1, 5'd0, 2'b10};
        end
`ifdef COMPRESSOR_SHIFT_EN
        else if (opcode == OP_IMM && funct3 == 3'b001 && funct7 == 7'b0000000 &&
                 rd == rs1 && rd != 5'd0 && rs2 != 5'd0) begin
            // C.SLLI (shamt lives in the rs2 field)
            c_ok = 1'b1;
            c16  = {3'b000, 1'b0, rd, rs2, 2'b10};
        end else if (opcode == OP_IMM && funct3 == 3'b101 && rd == rs1 && is_creg(rd) &&
                     rs2 != 5'd0 &&
                     (funct7 == 7'b0000000 || funct7 == 7'b0100000)) begin
            // C.SRLI / C.SRAI
            c_ok = 1'b1;
            c16  = {3'b100, 1'b0, 1'b0, funct7[5], rd[2:0], rs2, 2'b01};
        end else if (opcode == OP_IMM && funct3 == 3'b111 && rd == rs1 && is_creg(rd) &&
                     fits_simm6(imm_i)) begin
            // C.ANDI
            c_ok = 1'b1;
            c16  = {3'b100, imm_i[5], 2'b10, rd[2:0], imm_i[4:0], 2'b01};
        end
`endif
    end

    // ------------------------------------------------------------------
    // Packer FSM
    // ------------------------------------------------------------------
    state_t      state, state_next;
    logic [15:0] pending, pending_next;
    logic        load;
    logic [31:0] word_next;
    logic        accept;
    logic        flush_go;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign flush_go = flush && !in_valid && in_ready;
    assign idle     = (state == EMPTY);

    always_comb begin
        state_next   = state;
        pending_next = pending;
        load         = 1'b0;
        word_next    = 32'h0000_0000;
        case (state)
            EMPTY: begin
                if (accept) begin
                    if (c_ok) begin
                        pending_next = c16;
                        state_next   = HALF;
                    end else begin
                        load      = 1'b1;
                        word_next = instruction_in;
                    end
                end
            end
            HALF: begin
                if (accept) begin
                    load = 1'b1;
                    if (c_ok) begin
                        word_next  = {c16, pending};
                        state_next = EMPTY;
                    end else begin
                        // Low half completes this word, high half waits.
                        word_next    = {instruction_in[15:0], pending};
                        pending_next = instruction_in[31:16];
                    end
                end else if (flush_go) begin
                    load       = 1'b1;
                    word_next  = {16'h0001, pending};
                    state_next = EMPTY;
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= EMPTY;
            pending   <= 16'h0000;
            out_valid <= 1'b0;
            out_word  <= 32'h0000_0000;
        end else begin
            state   <= state_next;
            pending <= pending_next;
            if (load) begin
                out_valid <= 1'b1;
                out_word  <= word_next;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_instruction_compressor.sv
// -----------------------------------------------------------------------------
// tb_instruction_compressor
//
// Directed bench: an encoder vector table (each entry fed from EMPTY, padded
// with a flush when it compresses) plus hand-written packing, stall, reset and
// flush-priority sequences. Output words are checked against an expected queue.
// -----------------------------------------------------------------------------
module tb_instruction_compressor;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instruction_in;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_word;
    logic        idle;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_q[$];

    instruction_compressor dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .instruction_in (instruction_in),
        .flush          (flush),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_word       (out_word),
        .idle           (idle)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    // At the negedge, out_valid && out_ready means a transfer on the next edge.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_word got=%08h expected=<none>", out_word);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (out_word !== e) begin
                    bad++;
                    $display("FAIL out_word got=%08h expected=%08h", out_word, e);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%08h expected=%08h", name, act, exp);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic send(input logic [31:0] ins);
        bit got;
        got = 1'b0;
        in_valid = 1'b1;
        instruction_in = ins;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            got = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        total++;
        if (!got) begin
            bad++;
            $display("FAIL send_timeout instr=%08h got=not_accepted expected=accepted", ins);
        end
    endtask

    task automatic do_flush();
        bit done;
        done = 1'b0;
        flush = 1'b1;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            done = idle;
            @(posedge clk);
            #1;
        end
        flush = 1'b0;
        total++;
        if (!done) begin
            bad++;
            $display("FAIL flush_timeout got=idle_low expected=idle_high");
        end
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !out_valid) done = 1'b1;
        end
        @(posedge clk);
        #1;
        total++;
        if (!done) begin
            bad++;
            $display("FAIL drain_timeout got=%0d_left expected=0_left", exp_q.size());
        end
    endtask

    // ---------------- encoder vector table ----------------
    typedef struct {
        logic [31:0] instr;
        logic [31:0] exp;   // c16 in [15:0] when is16, else the pass-through word
        bit          is16;
    } vec_t;

    vec_t vecs[$];

    function automatic void add_vec(input logic [31:0] ins, input logic [31:0] e, input bit c);
        vec_t v;
        v.instr = ins;
        v.exp   = e;
        v.is16  = c;
        vecs.push_back(v);
    endfunction

    initial begin
        rst            = 1'b1;
        in_valid       = 1'b0;
        instruction_in = 32'h0;
        flush          = 1'b0;
        out_ready      = 1'b1;

        // ---------------- reset state ----------------
        #2;
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_out_word", out_word, 32'd0);
        check("reset_idle", {31'd0, idle}, 32'd1);
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #3;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // ---------------- table ----------------
        add_vec(32'h00550513, 32'h0515, 1);      // addi x10,x10,5     C.ADDI
        add_vec(32'hfff50513, 32'h157D, 1);      // addi x10,x10,-1    C.ADDI
        add_vec(32'hFE000513, 32'h5501, 1);      // li x10,-32         C.LI
        add_vec(32'h02050513, 32'h02050513, 0);  // addi imm=32 out of range
        add_vec(32'h00050513, 32'h00050513, 0);  // addi imm=0, rs1!=0
        add_vec(32'h00842483, 32'h4404, 1);      // lw x9,8(x8)        C.LW
        add_vec(32'h07C4A783, 32'h5CFC, 1);      // lw x15,124(x9)     C.LW max offset
        add_vec(32'h08042483, 32'h08042483, 0);  // lw offset 128
        add_vec(32'h00642483, 32'h00642483, 0);  // lw offset 6 misaligned
        add_vec(32'h00942223, 32'hC044, 1);      // sw x9,4(x8)        C.SW
        add_vec(32'h006282B3, 32'h929A, 1);      // add x5,x5,x6       C.ADD
        add_vec(32'h002000B3, 32'h808A, 1);      // mv x1,x2           C.MV
        add_vec(32'h000282B3, 32'h000282B3, 0);  // add rs2=x0
        add_vec(32'h40940433, 32'h8C05, 1);      // sub x8,x8,x9       C.SUB
        add_vec(32'h00B54533, 32'h8D2D, 1);      // xor x10,x10,x11    C.XOR
        add_vec(32'h0087E7B3, 32'h8FC1, 1);      // or x15,x15,x8      C.OR
        add_vec(32'h00A4F4B3, 32'h8CE9, 1);      // and x9,x9,x10      C.AND
        add_vec(32'h41040433, 32'h41040433, 0);  // sub with rs2=x16
        add_vec(32'h00008067, 32'h8082, 1);      // jr x1              C.JR
        add_vec(32'h000280E7, 32'h9282, 1);      // jalr x1,0(x5)      C.JALR
        add_vec(32'h00408067, 32'h00408067, 0);  // jalr imm=4
        add_vec(32'h008000EF, 32'h008000EF, 0);  // jal never compressed
        add_vec(32'h00000463, 32'h00000463, 0);  // beq never compressed
        add_vec(32'h00000001, 32'h00000001, 0);  // low bits != 11
`ifdef COMPRESSOR_SHIFT_EN
        add_vec(32'h00329293, 32'h028E, 1);      // slli x5,x5,3
        add_vec(32'h00445413, 32'h8011, 1);      // srli x8,x8,4
        add_vec(32'h4014D493, 32'h8485, 1);      // srai x9,x9,1
        add_vec(32'hFFF57513, 32'h997D, 1);      // andi x10,x10,-1
`else
        add_vec(32'h00329293, 32'h00329293, 0);
        add_vec(32'h00445413, 32'h00445413, 0);
        add_vec(32'h4014D493, 32'h4014D493, 0);
        add_vec(32'hFFF57513, 32'hFFF57513, 0);
`endif

        foreach (vecs[i]) begin
            if (vecs[i].is16) begin
                exp_q.push_back({16'h0001, vecs[i].exp[15:0]});
                send(vecs[i].instr);
                check("idle_after_c16", {31'd0, idle}, 32'd0);
                do_flush();
            end else begin
                exp_q.push_back(vecs[i].exp);
                send(vecs[i].instr);
            end
            drain();
            check("idle_after_vec", {31'd0, idle}, 32'd1);
        end

        // ---------------- two C.ADDI into one word ----------------
        exp_q.push_back(32'h157D0515);
        send(32'h00550513);
        send(32'hfff50513);
        drain();
        check("idle_pair", {31'd0, idle}, 32'd1);

        // ---------------- straddle + flush pad ----------------
        exp_q.push_back(32'h24834404);
        exp_q.push_back(32'h00010804);
        send(32'h00842483);
        send(32'h08042483);
        do_flush();
        drain();
        check("idle_straddle", {31'd0, idle}, 32'd1);

        // ---------------- mv + jr ----------------
        exp_q.push_back(32'h8082808A);
        send(32'h002000B3);
        send(32'h00008067);
        drain();

        // ---------------- chained straddles ----------------
        exp_q.push_back(32'h24830515);
        exp_q.push_back(32'h24830804);
        exp_q.push_back(32'h00010064);
        send(32'h00550513);
        send(32'h08042483);
        send(32'h00642483);
        do_flush();
        drain();

        // ---------------- instruction wins over simultaneous flush ----------------
        exp_q.push_back(32'h157D0515);
        send(32'h00550513);
        flush = 1'b1;
        send(32'hfff50513);
        repeat (3) @(posedge clk);
        #1;
        flush = 1'b0;
        drain();
        check("idle_flush_prio", {31'd0, idle}, 32'd1);

        // ---------------- output stall ----------------
        out_ready = 1'b0;
        exp_q.push_back(32'h08042483);
        exp_q.push_back(32'h00000013);
        send(32'h08042483);
        in_valid = 1'b1;
        instruction_in = 32'h00000013;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_out_valid", {31'd0, out_valid}, 32'd1);
            check("stall_out_word", out_word, 32'h08042483);
            check("stall_in_ready", {31'd0, in_ready}, 32'd0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("release_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        drain();

        // ---------------- reset while HALF ----------------
        send(32'h00550513);
        check("half_idle", {31'd0, idle}, 32'd0);
        rst = 1'b1;
        #2;
        check("rst_half_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_half_idle", {31'd0, idle}, 32'd1);
        rst = 1'b0;
        flush = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_flush_out_valid", {31'd0, out_valid}, 32'd0);
            @(posedge clk);
            #1;
        end
        flush = 1'b0;
        drain();

        // ---------------- shift rule ----------------
`ifdef COMPRESSOR_SHIFT_EN
        exp_q.push_back(32'h0515028E);
        send(32'h00329293);
        send(32'h00550513);
        drain();
        check("shift_idle", {31'd0, idle}, 32'd1);
`else
        exp_q.push_back(32'h00329293);
        send(32'h00329293);
        send(32'h00550513);
        drain();
        check("shift_idle", {31'd0, idle}, 32'd0);
        exp_q.push_back(32'h00010515);
        do_flush();
        drain();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instruction_compressor.md
# instruction_compressor

Streaming RV32I→RV32C compressor that sits between the program-image loader and instruction memory write port. It accepts one 32-bit instruction per handshake and re-encodes every eligible instruction into its 16-bit RVC form. It packs the resulting halfword stream little-endian into 32-bit memory words, emitting each word through a registered valid/ready output. 32-bit instructions may straddle word boundaries. A flush request pads a trailing odd halfword with C.NOP.

## Interface
- No parameters.
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  reset, asynchronous and active-high.
- in_valid  in  1  instruction_in valid.
- in_ready  out  1  block accepts instruction_in this cycle.
- instruction_in  in  32  uncompressed RV32I instruction.
- flush  in  1  level request: emit pending halfword, padded.
- out_valid  out  1  out_word valid.
- out_ready  in  1  consumer accepts out_word.
- out_word  out  32  packed word; earlier halfword in [15:0].
- idle  out  1  high when no halfword is pending.

## Operation
- Encoder rules, combinational, applied to instruction_in. The first matching rule wins. Registers x8–x15 map to rd′/rs1′/rs2′ = reg−8.
  - ADDI rd=rs1≠0, imm≠0, imm∈[−32,31] → C.ADDI.
  - ADDI rs1=x0, rd≠0, imm∈[−32,31] → C.LI.
  - LW rd, rs1 ∈ x8–x15, offset%4=0, offset∈[0,124] → C.LW. SW under the same conditions → C.SW.
  - ADD rd=rs1≠0, rs2≠0 → C.ADD.
  - ADD rs1=x0, rd≠0, rs2≠0 → C.MV.
  - SUB/XOR/OR/AND with rd=rs1, both in x8–x15, and rs2 in x8–x15 → C.SUB/C.XOR/C.OR/C.AND.
  - JALR imm=0, rs1≠0: rd=x0 → C.JR; rd=x1 → C.JALR.
  - Anything else, including instruction_in[1:0]≠2'b11, passes through as 32 bits.
- All encodings are standard RVC bit layouts. Branches and JAL are never compressed, because compression would alter their offsets.
- Packer state machine: EMPTY (no pending halfword) or HALF (pending[15:0] held).
  - EMPTY + 16-bit result → pending=c16, go to HALF, no output.
  - EMPTY + 32-bit result → out_word=instr, stay EMPTY.
  - HALF + 16-bit result → out_word={c16, pending}, go to EMPTY.
  - HALF + 32-bit result → out_word={instr[15:0], pending}, pending=instr[31:16], stay HALF.
  - flush with in_valid=0 in HALF → out_word={16'h0001, pending}, go to EMPTY.
  - flush with in_valid=0 in EMPTY → no action.
- Simultaneous in_valid and flush: the instruction is processed and the flush is ignored that cycle. The requester holds flush until idle=1.
- idle = (state==EMPTY).

## Timing
- Input handshake completes when in_valid && in_ready. A flush is accepted when flush && !in_valid && in_ready.
- in_ready = !out_valid || out_ready. This applies uniformly, including for transfers that produce no output.
- Output is registered: a word produced by an accept at edge N has out_valid high after edge N, i.e. 1-cycle latency.
- out_valid/out_word are held stable until out_ready is high.
- A new word may load in the same cycle the old one is taken, so sustained throughput is 1 transfer per cycle.
- Reset values: out_valid=0, out_word=0, pending=0, state=EMPTY, idle=1. in_ready=1 follows from out_valid=0.
- Reset mid-operation drops any pending halfword and any un-taken output word immediately (asynchronous).

## Configuration
- COMPRESSOR_SHIFT_EN defined adds these rules:
  - SLLI rd=rs1≠0, shamt≠0 → C.SLLI.
  - SRLI/SRAI with rd=rs1 ∈ x8–x15, shamt≠0 → C.SRLI/C.SRAI.
  - ANDI with rd=rs1 ∈ x8–x15, imm∈[−32,31] → C.ANDI.
- Undefined: these instructions pass through uncompressed. All other behaviour is identical.

## Test plan
- addi x10,x10,5 (0x00550513), then addi x10,x10,−1 (0xfff50513), out_ready=1 → a single word 0x157D0515; idle=1 afterwards.
- lw x9,8(x8) (0x00842483), then lw x9,128(x8) (0x08042483), then flush → words 0x24834404, then 0x00010804; idle=1.
- add x1,x0,x2 (0x002000b3), then jalr x0,0(x1) (0x00008067) → word 0x8082808A.
- Output stall: hold out_ready=0 with a word pending → out_word is stable, in_ready=0, and no input is accepted. Raise out_ready → the word transfers, and a new accept is possible in the same cycle.
- Reset in HALF: after 0x00550513 is accepted, pulse rst → out_valid=0 and idle=1. A following flush emits nothing.
- Shift rule: slli x5,x5,3 (0x00329293), then 0x00550513 → with COMPRESSOR_SHIFT_EN, word 0x0515028E. Without it, word 0x00329293 is emitted and the block is left in HALF with pending 0x0515.
